// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the parallel-in/serial-out serializer
//
// Contents:
//   state_t : serializer state (IDLE, SHIFT, PARITY; PARITY is reached only
//             when PISO_PARITY_EN is defined)
//   cnt_w   : width of the bit counter for a given word width

package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - word-to-bitstream serializer, MSB first, gapless back-to-back
//
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit per word).
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   IDLE_BIT   level on dout between frames
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  upstream offers load_data
//   load_ready  a word can be accepted this cycle
//   load_data   parallel word, bit WIDTH-1 leaves first
//   dout        serial bit
//   dout_valid  dout carries a frame bit
//   busy        a frame is in progress
//   frame_done  last bit of the frame is on dout

module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bit_cnt, cnt_n;
  logic             accept;
  logic             dout_n, dout_valid_n, frame_done_n;
`ifdef PISO_PARITY_EN
  logic             par, par_n;
`endif

  // Ready depends on registered state only. The rst term keeps it low while
  // reset is held, since the reset state itself (IDLE) would otherwise say ready.
`ifdef PISO_PARITY_EN
  assign load_ready = !rst && ((state == IDLE) || (state == PARITY));
`else
  assign load_ready = !rst && ((state == IDLE) || ((state == SHIFT) && (bit_cnt == LAST)));
`endif

  assign accept = load_valid && load_ready;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = bit_cnt;
`ifdef PISO_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = load_data;
          cnt_n   = '0;
`ifdef PISO_PARITY_EN
          par_n   = ^load_data;
`endif
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST) begin
`ifdef PISO_PARITY_EN
          state_n = PARITY;
          cnt_n   = '0;
`else
          // Last data bit: reload in the same edge so the stream has no gap.
          if (accept) begin
            shreg_n = load_data;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
`endif
        end else begin
          shreg_n = shreg << 1;
          cnt_n   = bit_cnt + CW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = load_data;
          cnt_n   = '0;
          par_n   = ^load_data;
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are precomputed from the next state so they come straight off flops.
    dout_valid_n = (state_n != IDLE);
    dout_n       = IDLE_BIT;
    if (state_n == SHIFT) dout_n = shreg_n[WIDTH-1];
`ifdef PISO_PARITY_EN
    if (state_n == PARITY) dout_n = par_n;
    frame_done_n = (state_n == PARITY);
`else
    frame_done_n = (state_n == SHIFT) && (cnt_n == LAST);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= cnt_n;
`ifdef PISO_PARITY_EN
      par        <= par_n;
`endif
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      busy       <= dout_valid_n;
      frame_done <= frame_done_n;
    end
  end

endmodule
